// File: rtl/instr_fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// The queue uses the slave modport; fetch/decode (or a bench) use master.
interface instr_fetch_queue_if #(
   parameter int ADDR_W = 3
);
   logic              Push_IN;
   logic [31:0]       Instr_IN;
   logic [31:0]       Instr_PC_IN;
   logic              Full_OUT;
   logic              Drop_OUT;
   logic              Request_Instr1_IN;
   logic              Freeze_IN;
   logic              Flush_IN;
   logic [31:0]       Instr1_OUT;
   logic [31:0]       Instr_PC_OUT;
   logic [31:0]       Instr_PC_Plus4_OUT;
   logic              Instr1_Valid_OUT;
   logic [ADDR_W:0]   Count_OUT;

   modport master (
      output Push_IN, Instr_IN, Instr_PC_IN, Request_Instr1_IN, Freeze_IN, Flush_IN,
      input  Full_OUT, Drop_OUT, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT,
             Instr1_Valid_OUT, Count_OUT
   );

   modport slave (
      input  Push_IN, Instr_IN, Instr_PC_IN, Request_Instr1_IN, Freeze_IN, Flush_IN,
      output Full_OUT, Drop_OUT, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT,
             Instr1_Valid_OUT, Count_OUT
   );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch-to-decode instruction FIFO with a separate head register, an empty-queue
// bypass into the head, and a flush that drops all wrong-path entries.
module instr_fetch_queue #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input logic                CLK,
   input logic                RESET,
   instr_fetch_queue_if.slave bus
);
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
   } entry_t;

   entry_t              mem_r [DEPTH];
   entry_t              head_r;
   logic                valid_r;
   logic [ADDR_W-1:0]   rd_ptr_r;
   logic [ADDR_W-1:0]   wr_ptr_r;
   logic [ADDR_W:0]     count_r;
   logic                full_r;
   logic                drop_r;

   entry_t              push_entry_s;
   logic                pop_s;
   logic                push_ok_s;
   logic                drop_s;
   logic                head_free_s;
   logic                backing_empty_s;
   logic                mem_wr_s;
   logic [ADDR_W:0]     count_nxt_s;

   // Handshake decode and next-count arithmetic.
   always_comb begin
      push_entry_s.instr    = bus.Instr_IN;
      push_entry_s.pc       = bus.Instr_PC_IN;
      push_entry_s.pc_plus4 = bus.Instr_PC_IN + 32'd4;
      pop_s           = valid_r & bus.Request_Instr1_IN & ~bus.Freeze_IN;
      push_ok_s       = bus.Push_IN & (~full_r | pop_s) & ~bus.Flush_IN;
      drop_s          = bus.Push_IN & full_r & ~pop_s & ~bus.Flush_IN;
      head_free_s     = ~valid_r | pop_s;
      // The backing store never holds DEPTH entries, so equal pointers mean empty.
      backing_empty_s = (rd_ptr_r == wr_ptr_r);
      mem_wr_s        = push_ok_s & ~(head_free_s & backing_empty_s);
      count_nxt_s     = count_r + {{ADDR_W{1'b0}}, push_ok_s} - {{ADDR_W{1'b0}}, pop_s};
   end

   // Backing store write port; contents need no reset.
   always_ff @(posedge CLK) begin
      if (mem_wr_s && !RESET) begin
         mem_r[wr_ptr_r] <= push_entry_s;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Head register, pointers, occupancy and status flags.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         head_r   <= '0;
         valid_r  <= 1'b0;
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
         drop_r   <= 1'b0;
      end else if (bus.Flush_IN) begin
         head_r.instr <= 32'd0;
         valid_r      <= 1'b0;
         rd_ptr_r     <= '0;
         wr_ptr_r     <= '0;
         count_r      <= '0;
         full_r       <= 1'b0;
         drop_r       <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == (ADDR_W+1)'(DEPTH));
         drop_r  <= drop_s;
         if (head_free_s) begin
            if (!backing_empty_s) begin
               head_r   <= mem_r[rd_ptr_r];
               valid_r  <= 1'b1;
               rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end else if (push_ok_s) begin
               head_r  <= push_entry_s;
               valid_r <= 1'b1;
            end else begin
               head_r.instr <= 32'd0;
               valid_r      <= 1'b0;
            end
         end else begin
            head_r  <= head_r;
            valid_r <= valid_r;
         end
         if (mem_wr_s) begin
            wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
      end
   end

   assign bus.Instr1_OUT         = head_r.instr;
   assign bus.Instr_PC_OUT       = head_r.pc;
   assign bus.Instr_PC_Plus4_OUT = head_r.pc_plus4;
   assign bus.Instr1_Valid_OUT   = valid_r;
   assign bus.Count_OUT          = count_r;
   assign bus.Full_OUT           = full_r;
   assign bus.Drop_OUT           = drop_r;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a queue-based reference model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_instr_fetch_queue;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   logic CLK = 1'b0;
   logic RESET;
   int   errors = 0;
   int   checks = 0;

   instr_fetch_queue_if #(.ADDR_W(ADDR_W)) bus();

   instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain FIFO of {instr, pc} plus the last head PC.
   logic [63:0] m_q[$];
   logic [31:0] m_pc, m_pc4;
   bit          m_drop, m_ok = 1'b0;
   bit          m_full, m_pop, m_acc;

   always @(posedge CLK) begin
      if (RESET) begin
         m_q.delete();
         m_pc = 32'd0; m_pc4 = 32'd0; m_drop = 1'b0; m_ok = 1'b1;
      end else if (bus.Flush_IN) begin
         m_q.delete();
         m_drop = 1'b0;
      end else begin
         m_full = (m_q.size() == DEPTH);
         m_pop  = (m_q.size() != 0) && bus.Request_Instr1_IN && !bus.Freeze_IN;
         m_acc  = bus.Push_IN && (!m_full || m_pop);
         m_drop = bus.Push_IN && m_full && !m_pop;
         if (m_pop) void'(m_q.pop_front());
         if (m_acc) m_q.push_back({bus.Instr_IN, bus.Instr_PC_IN});
      end
      if (m_q.size() != 0) begin
         m_pc  = m_q[0][31:0];
         m_pc4 = m_q[0][31:0] + 32'd4;
      end
   end

   // Compare DUT against the model mid-cycle, away from the active edge.
   always @(negedge CLK) begin
      if (m_ok) begin
         chk("valid", {31'd0, bus.Instr1_Valid_OUT}, {31'd0, m_q.size() != 0});
         chk("instr", bus.Instr1_OUT, (m_q.size() != 0) ? m_q[0][63:32] : 32'd0);
         chk("pc", bus.Instr_PC_OUT, m_pc);
         chk("pc4", bus.Instr_PC_Plus4_OUT, m_pc4);
         chk("count", {28'd0, bus.Count_OUT}, m_q.size());
         chk("full", {31'd0, bus.Full_OUT}, {31'd0, m_q.size() == DEPTH});
         chk("drop", {31'd0, bus.Drop_OUT}, {31'd0, m_drop});
      end
   end

   task automatic cyc(input bit push, input logic [31:0] ins, input logic [31:0] pc,
                      input bit req, input bit frz, input bit fl, input bit rst);
      bus.Push_IN           = push;
      bus.Instr_IN          = ins;
      bus.Instr_PC_IN       = pc;
      bus.Request_Instr1_IN = req;
      bus.Freeze_IN         = frz;
      bus.Flush_IN          = fl;
      RESET                 = rst;
      @(posedge CLK);
      #1;
   endtask

   task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
      cyc(1'b1, ins, pc, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle();
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic flush();
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic pop1();
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_valid", {31'd0, bus.Instr1_Valid_OUT}, 32'd0);
      chk("rst_count", {28'd0, bus.Count_OUT}, 32'd0);
      chk("rst_pc4", bus.Instr_PC_Plus4_OUT, 32'd0);

      // First push lands in the head the next cycle.
      push1(32'h2008_0005, 32'h0040_0000);
      chk("t1_valid", {31'd0, bus.Instr1_Valid_OUT}, 32'd1);
      chk("t1_instr", bus.Instr1_OUT, 32'h2008_0005);
      chk("t1_pc", bus.Instr_PC_OUT, 32'h0040_0000);
      chk("t1_pc4", bus.Instr_PC_Plus4_OUT, 32'h0040_0004);
      chk("t1_count", {28'd0, bus.Count_OUT}, 32'd1);
      flush();

      // Fill to capacity, overflow once, then drain in order.
      for (int i = 0; i < 8; i++) push1(32'h0000_1000 + i, 32'h1000_0000 + 4 * i);
      chk("t2_full", {31'd0, bus.Full_OUT}, 32'd1);
      chk("t2_count", {28'd0, bus.Count_OUT}, 32'd8);
      push1(32'h0000_DEAD, 32'h2000_0000);
      chk("t2_drop", {31'd0, bus.Drop_OUT}, 32'd1);
      chk("t2_count9", {28'd0, bus.Count_OUT}, 32'd8);
      idle();
      chk("t2_drop_off", {31'd0, bus.Drop_OUT}, 32'd0);
      for (int k = 1; k <= 8; k++) begin
         pop1();
         if (k < 8) chk("t2_order", bus.Instr1_OUT, 32'h0000_1000 + k);
         chk("t2_drain", {28'd0, bus.Count_OUT}, 8 - k);
      end
      chk("t2_empty", {31'd0, bus.Instr1_Valid_OUT}, 32'd0);
      chk("t2_nop", bus.Instr1_OUT, 32'd0);
      chk("t2_pc_hold", bus.Instr_PC_OUT, 32'h1000_001C);

      // Full queue with simultaneous push and pop.
      for (int i = 0; i < 8; i++) push1(32'h0000_2000 + i, 32'h3000_0000 + 4 * i);
      for (int j = 0; j < 5; j++) begin
         cyc(1'b1, 32'h0000_2008 + j, 32'h3000_0020 + 4 * j, 1'b1, 1'b0, 1'b0, 1'b0);
         chk("t3_count", {28'd0, bus.Count_OUT}, 32'd8);
         chk("t3_nodrop", {31'd0, bus.Drop_OUT}, 32'd0);
      end
      chk("t3_head", bus.Instr1_OUT, 32'h0000_2005);
      flush();

      // Freeze holds the head; release drains one per cycle.
      for (int i = 0; i < 3; i++) push1(32'h0000_3000 + i, 32'h4000_0000 + 4 * i);
      for (int j = 0; j < 4; j++) begin
         cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
         chk("t4_frz_head", bus.Instr1_OUT, 32'h0000_3000);
         chk("t4_frz_count", {28'd0, bus.Count_OUT}, 32'd3);
      end
      pop1();
      chk("t4_head1", bus.Instr1_OUT, 32'h0000_3001);
      chk("t4_count2", {28'd0, bus.Count_OUT}, 32'd2);
      pop1();
      chk("t4_count1", {28'd0, bus.Count_OUT}, 32'd1);
      pop1();
      chk("t4_count0", {28'd0, bus.Count_OUT}, 32'd0);

      // Flush coinciding with a push.
      for (int i = 0; i < 5; i++) push1(32'h0000_5000 + i, 32'h5000_0000 + 4 * i);
      cyc(1'b1, 32'h0000_5555, 32'h5000_0100, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t5_valid", {31'd0, bus.Instr1_Valid_OUT}, 32'd0);
      chk("t5_instr", bus.Instr1_OUT, 32'd0);
      chk("t5_count", {28'd0, bus.Count_OUT}, 32'd0);
      chk("t5_full", {31'd0, bus.Full_OUT}, 32'd0);
      idle();
      chk("t5_absent", {28'd0, bus.Count_OUT}, 32'd0);

      // PC+4 wraps at the top of the address space.
      push1(32'h0000_6000, 32'hFFFF_FFFC);
      chk("t6_pc", bus.Instr_PC_OUT, 32'hFFFF_FFFC);
      chk("t6_pc4", bus.Instr_PC_Plus4_OUT, 32'h0000_0000);
      pop1();

      // Reset mid-stream.
      for (int i = 0; i < 4; i++) push1(32'h0000_7000 + i, 32'h7000_0000 + 4 * i);
      cyc(1'b1, 32'h0000_7004, 32'h7000_0010, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t7_valid", {31'd0, bus.Instr1_Valid_OUT}, 32'd0);
      chk("t7_instr", bus.Instr1_OUT, 32'd0);
      chk("t7_pc", bus.Instr_PC_OUT, 32'd0);
      chk("t7_pc4", bus.Instr_PC_Plus4_OUT, 32'd0);
      chk("t7_count", {28'd0, bus.Count_OUT}, 32'd0);
      push1(32'h0000_7777, 32'h0000_0100);
      chk("t7_only", bus.Instr1_OUT, 32'h0000_7777);
      chk("t7_only_pc4", bus.Instr_PC_Plus4_OUT, 32'h0000_0104);
      chk("t7_only_count", {28'd0, bus.Count_OUT}, 32'd1);
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
